mux_sweep_ctrl: RTL and testbench

- Sequencing controller for the 3-input mux-expression datapath (inputs a, b, c; output s).
- On a start request it drives all eight input combinations in ascending order and waits a programmable settle time for each.
- It samples s into an 8-bit truth-table register, counts mismatches against an expected table, then reports done and pass.
- It sits between a test or host controller and the combinational mux-expression instance.

---
 rtl/mux_sweep_ctrl.sv | 114 +++++++++++
 tb/tb_mux_sweep_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_ctrl.sv
// mux_sweep_ctrl: sweeps the eight {a,b,c} input combinations of a 3-input
// mux-expression datapath in ascending order. Each vector is held for SETTLE
// cycles and then s is sampled for one cycle. The controller builds a truth
// table, counts the vectors that differ from EXPECTED, and reports done/pass.
//
// Handshake: start is a level request. It is accepted on any rising edge where
// the controller is in IDLE and reset is low. It is ignored while busy. done
// is a one-cycle registered pulse, and the controller is back in IDLE during
// that cycle, so a start held high there begins the next sweep on that edge.
module mux_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] err_cnt,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       mismatch;
  logic [3:0] err_next;

  // Compare the sample against the expected table. The maximum count is 8, so
  // a 4-bit counter cannot wrap.
  assign mismatch = (s_in != EXPECTED[idx]);
  assign err_next = err_cnt + {3'b000, mismatch};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WAIT;
      WAIT:    if (cnt == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = (idx == 3'd7) ? IDLE : WAIT;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: vector index, settle counter, table, error count, pass, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 3'd0;
      cnt       <= 4'd0;
      table_out <= 8'h00;
      err_cnt   <= 4'd0;
      pass      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= 3'd0;
            cnt       <= 4'd0;
            table_out <= 8'h00;
            err_cnt   <= 4'd0;
            pass      <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != SETTLE_LAST) cnt <= cnt + 4'd1;
        end
        SAMPLE: begin
          table_out[idx] <= s_in;
          err_cnt        <= err_next;
          cnt            <= 4'd0;
          if (idx == 3'd7) begin
            idx  <= 3'd0;
            done <= 1'b1;
            pass <= (err_next == 4'd0);
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registers only; s_in never reaches an output combinationally.
  always_comb begin
    busy  = (state != IDLE);
    a_out = idx[2];
    b_out = idx[1];
    c_out = idx[0];
  end

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// tb_mux_sweep_ctrl: directed bench for mux_sweep_ctrl. It uses two
// instances, one with the default SETTLE=2 and one with SETTLE=1. A small
// behavioural datapath (s = XNOR(b,c)) feeds s_in, and s_in can instead be
// forced to 0 or inverted. An expected {table, err, pass} result is queued
// when each sweep starts and is compared when done pulses.
module tb_mux_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sel;          // 0: exercise dut_a (SETTLE=2), 1: dut_b (SETTLE=1)
  int         mode;         // 0: real datapath, 1: s forced 0, 2: s inverted

  logic       start_a, s_a, a_a, b_a, c_a, busy_a, done_a, pass_a;
  logic [7:0] table_a;
  logic [3:0] err_a;
  logic       start_b, s_b, a_b, b_b, c_b, busy_b, done_b, pass_b;
  logic [7:0] table_b;
  logic [3:0] err_b;

  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_table;
  logic [3:0] o_err;

  logic [12:0] exp_q[$];    // {table[7:0], err[3:0], pass}
  int          n_assert = 0;
  int          n_fail   = 0;

  localparam logic [7:0] EXP_TABLE = 8'h99;

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Behavioural datapath: s = XNOR(b,c).
  function automatic logic dp(input logic [2:0] v);
    return ~(v[1] ^ v[0]);
  endfunction

  function automatic logic s_model(input int m, input logic [2:0] v);
    if (m == 1) return 1'b0;
    if (m == 2) return ~dp(v);
    return dp(v);
  endfunction

  assign s_a     = s_model(mode, {a_a, b_a, c_a});
  assign s_b     = s_model(mode, {a_b, b_b, c_b});
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign o_abc   = sel ? {a_b, b_b, c_b} : {a_a, b_a, c_a};
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_pass  = sel ? pass_b  : pass_a;
  assign o_table = sel ? table_b : table_a;
  assign o_err   = sel ? err_b   : err_a;

  mux_sweep_ctrl #(.SETTLE(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .s_in(s_a),
    .a_out(a_a), .b_out(b_a), .c_out(c_a), .busy(busy_a), .done(done_a),
    .table_out(table_a), .err_cnt(err_a), .pass(pass_a)
  );

  mux_sweep_ctrl #(.SETTLE(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .s_in(s_b),
    .a_out(a_b), .b_out(b_b), .c_out(c_b), .busy(busy_b), .done(done_b),
    .table_out(table_b), .err_cnt(err_b), .pass(pass_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expected result of a sweep in the given s_in mode.
  task automatic push_expected(input int m);
    logic [7:0] t;
    logic [3:0] e;
    logic [2:0] v;
    e = 4'd0;
    for (int i = 0; i < 8; i++) begin
      v    = 3'(i);
      t[i] = s_model(m, v);
      if (t[i] != EXP_TABLE[i]) e = e + 4'd1;
    end
    exp_q.push_back({t, e, (e == 4'd0)});
  endtask

  // Run one sweep on the selected DUT and check it cycle by cycle.
  // chained: the caller is already at the negedge just after the accepting edge.
  // hold: start stays high, so another sweep must begin on the done edge.
  // pulse: start toggles randomly during the sweep and must be ignored.
  task automatic run_sweep(input int settle, input int m, input bit pulse,
                           input bit hold, input bit chained);
    int          n;
    logic [12:0] e;
    n    = 8 * (settle + 1);
    mode = m;
    push_expected(m);
    if (!chained) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk);
    end
    chk("start_busy", o_busy, 1);
    chk("start_abc", o_abc, 0);
    chk("start_table_clr", o_table, 0);
    chk("start_err_clr", o_err, 0);
    chk("start_pass_clr", o_pass, 0);
    if (!hold) start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (pulse) start = (k < n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (k < n) begin
        chk("sweep_abc", o_abc, k / (settle + 1));
        chk("sweep_busy", o_busy, 1);
        chk("sweep_done_low", o_done, 0);
      end else begin
        chk("done_pulse", o_done, 1);
        chk("done_busy_low", o_busy, 0);
        chk("done_abc", o_abc, 0);
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("table_out", o_table, e[12:5]);
          chk("err_cnt", o_err, e[4:1]);
          chk("pass", o_pass, e[0]);
        end
      end
    end
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    if (hold) begin
      chk("restart_busy", o_busy, 1);
      chk("restart_table_clr", o_table, 0);
    end else begin
      chk("after_busy_low", o_busy, 0);
      chk("after_table_hold", o_table, e[12:5]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    // Reset state, with start held high to confirm that reset wins.
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_abc", {a_a, b_a, c_a}, 0);
    chk("rst_table", table_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_busy_b", busy_b, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // 1: real datapath, SETTLE=2.
    run_sweep(2, 0, 1'b0, 1'b0, 1'b0);
    // 2: s_in forced to 0.
    run_sweep(2, 1, 1'b0, 1'b0, 1'b0);
    // 3: start pulsed during the sweep.
    run_sweep(2, 0, 1'b1, 1'b0, 1'b0);

    // 4: reset asserted while idx == 4.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_reset_abc", o_abc, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_abc", o_abc, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_table", o_table, 0);
    chk("midrst_err", o_err, 0);
    chk("midrst_done", o_done, 0);
    repeat (30) begin
      @(negedge clk);
      chk("midrst_no_done", o_done, 0);
    end
    run_sweep(2, 0, 1'b0, 1'b0, 1'b0);

    // 5: start held high -> back-to-back sweeps.
    run_sweep(2, 0, 1'b0, 1'b1, 1'b0);
    run_sweep(2, 0, 1'b0, 1'b1, 1'b1);
    run_sweep(2, 0, 1'b0, 1'b0, 1'b1);

    // 6: SETTLE=1 instance with s_in inverted (err_cnt 8, no wrap).
    @(negedge clk) sel = 1'b1;
    run_sweep(1, 2, 1'b0, 1'b0, 1'b0);
    run_sweep(1, 0, 1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
